// File: rtl/deo_salva_pwm_deadtime.sv
// Avalon-MM PWM generator with complementary dead-time gates, shadowed period/duty/dead-time
// registers, timer sync restart and a period-end interrupt.
module deo_salva_pwm_deadtime #(
   parameter logic [15:0]         PERIOD_RST = 16'd999,
   parameter logic [15:0]         DUTY_RST   = 16'd0,
   parameter int                  DT_WIDTH   = 8,
   parameter logic [DT_WIDTH-1:0] DT_RST     = DT_WIDTH'(10)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        irq,
   input  logic        sync_in,
   output logic        pwm_h,
   output logic        pwm_l
);

   logic                running;
   logic                period_done;
   logic                sync_en;
   logic                irq_en;
   logic [15:0]         per_p;
   logic [15:0]         duty_p;
   logic [DT_WIDTH-1:0] dt_p;
   logic [15:0]         per_a;
   logic [15:0]         duty_a;
   logic [DT_WIDTH-1:0] dt_a;
   logic [15:0]         cnt;
   logic [DT_WIDTH-1:0] dt_cnt;
   logic                raw_q;
   logic                start_q;

   logic                wr;
   logic                wr_status;
   logic                wr_control;
   logic                start;
   logic                stop;
   logic                period_end;
   logic                raw;
   logic                dt_edge;
   logic                dt_ok;
   logic [15:0]         dt_ext;
   logic [15:0]         rd_mux;

   always_comb begin
      wr         = chipselect && !write_n;
      wr_status  = wr && (address == 3'd0);
      wr_control = wr && (address == 3'd1);
      start      = wr_control && writedata[2];
      stop       = wr_control && writedata[3];
      // a sync pulse at cnt==0 would be a second period end back to back, so it is ignored
      period_end = running && ((cnt == per_a) || (sync_en && sync_in && (cnt != 16'd0)));
      raw        = running && (cnt < duty_a);
      // START counts as an edge so both gates stay low for a full dead time after it
      dt_edge    = (raw != raw_q) || start_q;
      dt_ok      = dt_edge ? (dt_a == '0) : (dt_cnt <= DT_WIDTH'(1));
      dt_ext     = '0;
      dt_ext[DT_WIDTH-1:0] = dt_p;
      case (address)
         3'd0:    rd_mux = {14'd0, running, period_done};
         3'd1:    rd_mux = {14'd0, sync_en, irq_en};
         3'd2:    rd_mux = per_p;
         3'd3:    rd_mux = duty_p;
         3'd4:    rd_mux = dt_ext;
         3'd5:    rd_mux = cnt;
         default: rd_mux = '0;
      endcase
   end

   assign irq = period_done && irq_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         running     <= 1'b0;
         period_done <= 1'b0;
         sync_en     <= 1'b0;
         irq_en      <= 1'b0;
         per_p       <= PERIOD_RST;
         duty_p      <= DUTY_RST;
         dt_p        <= DT_RST;
         per_a       <= PERIOD_RST;
         duty_a      <= DUTY_RST;
         dt_a        <= DT_RST;
         cnt         <= '0;
         dt_cnt      <= '0;
         raw_q       <= 1'b0;
         start_q     <= 1'b0;
         pwm_h       <= 1'b0;
         pwm_l       <= 1'b0;
         readdata    <= '0;
      end else begin
         readdata <= rd_mux;

         if (wr_control) begin
            sync_en <= writedata[1];
            irq_en  <= writedata[0];
         end
         if (wr && (address == 3'd2)) per_p  <= writedata;
         if (wr && (address == 3'd3)) duty_p <= writedata;
         if (wr && (address == 3'd4)) dt_p   <= writedata[DT_WIDTH-1:0];

         if (start || period_end) begin
            per_a  <= per_p;
            duty_a <= duty_p;
            dt_a   <= dt_p;
         end

         if (start || period_end) begin
            cnt <= '0;
         end else if (running) begin
            cnt <= cnt + 16'd1;
         end

         if (start) begin
            running <= 1'b1;
         end else if (stop) begin
            running <= 1'b0;
         end

         if (wr_status) begin
            period_done <= 1'b0;
         end else if (period_end) begin
            period_done <= 1'b1;
         end

         raw_q   <= raw;
         start_q <= start;

         if (dt_edge) begin
            dt_cnt <= dt_a;
         end else if (dt_cnt != '0) begin
            dt_cnt <= dt_cnt - DT_WIDTH'(1);
         end

         pwm_h <= raw && dt_ok;
         pwm_l <= running && !raw && dt_ok;
      end
   end

endmodule
